pc_npc_unit: RTL and testbench
==============================

// Module: pc_npc_unit
// PURPOSE
//  Holds the SPARC PC/nPC pair and sequences delayed control transfers.
//  Consumes the 32-bit branch/call target from the branch target adder and presents
//  the next fetch address to instruction memory. Implements delay slots, the annul bit
//  and a one-cycle trap-entry state. Sits between branch target generation and fetch.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value after reset; nPC resets to RESET_PC+4
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high
//  advance      in   1   pipeline step: instruction at pc completes and a new one is fetched
//  ctrl_xfer    in   1   instruction at pc is a control transfer (Bicc/CALL/JMPL)
//  taken        in   1   transfer taken (CALL/JMPL always drive 1)
//  uncond       in   1   transfer is branch-always (BA)
//  annul_bit    in   1   'a' bit of the branch instruction
//  target       in   32  branch/call target address from the target adder
//  trap         in   1   trap request, level-sampled
//  trap_vec     in   32  trap handler address (from TBR)
//  pc           out  32  current instruction address
//  npc          out  32  next instruction address
//  annul_slot   out  1   instruction at pc is annulled (no side effects)
//  saved_pc     out  32  pc captured at trap entry
//  saved_npc    out  32  npc captured at trap entry
//  trap_ack     out  1   one-cycle pulse on trap entry
//  align_err    out  1   sticky: a taken target had target[1:0]!=0
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, npc=RESET_PC+4, annul_slot=0, saved_pc=0, saved_npc=0,
//   trap_ack=0, align_err=0, state=RUN. All outputs are registered.
//  States: RUN, TRAP_ENTRY.
//  RUN, trap=1 (highest priority, independent of advance): saved_pc<=pc, saved_npc<=npc,
//   pc<=trap_vec, npc<=trap_vec+4, annul_slot<=0, trap_ack<=1, -> TRAP_ENTRY.
//  TRAP_ENTRY: pc/npc hold, advance and trap ignored, trap_ack<=0, -> RUN next cycle.
//  RUN, trap=0, advance=0: all registers hold.
//  RUN, trap=0, advance=1: pc<=npc always; npc and annul_slot are selected below.
//   annul_slot=1: ctrl_xfer/taken ignored; npc<=npc+4; annul_slot<=0.
//   ctrl_xfer=0: npc<=npc+4; annul_slot<=0.
//   ctrl_xfer=1, taken=1: npc<={target[31:2],2'b00}; annul_slot<=annul_bit&uncond;
//    align_err<=1 if target[1:0]!=0.
//   ctrl_xfer=1, taken=0: npc<=npc+4; annul_slot<=annul_bit.
//  Arithmetic: npc+4 and trap_vec+4 are modulo 2^32 (FFFF_FFFC+4 -> 0000_0000).
//  Latency: branch decision at cycle N, target appears on npc at N+1 and on pc at N+2
//   (one delay slot).
//  Back-to-back transfers: a transfer in a delay slot (DCTI couple) is honoured;
//   pc<=old target, npc<=new target.
//  align_err clears only on reset. A trap raised in the same cycle as advance wins;
//   the branch update is discarded.
// TESTING
//  1 reset, 3 advances, no transfers -> pc 0,4,8,C; npc 4,8,C,10
//  2 pc=8: taken Bicc, target=0x100, a=0 -> next pc=C, npc=0x100; then pc=0x100, annul_slot=0
//  3 pc=8: untaken Bicc with a=1 -> pc=C with annul_slot=1; a transfer at C is ignored; then pc=0x10
//  4 BA,a with target=0x40 -> delay slot annulled, then pc=0x40; a 0x42 target sets align_err, npc=0x40
//  5 trap with trap_vec=0x800, pc=0x20, advance=1 -> saved_pc=0x20, saved_npc=0x24, pc=0x800,
//    trap_ack for 1 cycle, pc holds 1 cycle
//  6 npc=FFFF_FFFC, advance -> npc wraps to 0; assert reset mid-branch -> pc=RESET_PC immediately

Source files
------------

// File: rtl/pc_npc_unit.sv
// rtl/pc_npc_unit.sv - SPARC PC/nPC sequencer with delayed transfers, annul and trap entry
//
// Holds the PC/nPC pair. Each advance retires the instruction at pc and moves the
// pair forward. A taken transfer lands in npc, so the following instruction (the
// delay slot) still executes unless annulled. A trap overrides everything and spends
// one cycle in TRAP_ENTRY, with pc/npc frozen, before normal sequencing resumes.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   advance                     pipeline step
//   ctrl_xfer, taken, uncond    transfer decode for the instruction at pc
//   annul_bit, target           'a' bit and target address of that transfer
//   trap, trap_vec              trap request and handler address
//   pc, npc                     current / next instruction address
//   annul_slot                  instruction at pc is annulled
//   saved_pc, saved_npc         pc/npc captured at trap entry
//   trap_ack                    one-cycle pulse on trap entry
//   align_err                   sticky misaligned taken target
module pc_npc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        advance,
   input  logic        ctrl_xfer,
   input  logic        taken,
   input  logic        uncond,
   input  logic        annul_bit,
   input  logic [31:0] target,
   input  logic        trap,
   input  logic [31:0] trap_vec,
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic        annul_slot,
   output logic [31:0] saved_pc,
   output logic [31:0] saved_npc,
   output logic        trap_ack,
   output logic        align_err
);

   typedef enum logic {
      ST_RUN        = 1'b0,
      ST_TRAP_ENTRY = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] npc_q, npc_d;
   logic        annul_slot_q, annul_slot_d;
   logic [31:0] saved_pc_q, saved_pc_d;
   logic [31:0] saved_npc_q, saved_npc_d;
   logic        trap_ack_q, trap_ack_d;
   logic        align_err_q, align_err_d;

   // Both increments wrap modulo 2^32 by truncation to 32 bits.
   logic [31:0] npc_plus4;
   logic [31:0] trap_vec_plus4;

   assign npc_plus4      = npc_q + 32'd4;
   assign trap_vec_plus4 = trap_vec + 32'd4;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      npc_d        = npc_q;
      annul_slot_d = annul_slot_q;
      saved_pc_d   = saved_pc_q;
      saved_npc_d  = saved_npc_q;
      trap_ack_d   = 1'b0;
      align_err_d  = align_err_q;

      case (state_q)
         ST_RUN: begin
            if (trap) begin
               // Trap wins over a simultaneous advance; the branch update is dropped.
               saved_pc_d   = pc_q;
               saved_npc_d  = npc_q;
               pc_d         = trap_vec;
               npc_d        = trap_vec_plus4;
               annul_slot_d = 1'b0;
               trap_ack_d   = 1'b1;
               state_d      = ST_TRAP_ENTRY;
            end else if (advance) begin
               pc_d = npc_q;
               if (annul_slot_q || !ctrl_xfer) begin
                  // An annulled instruction cannot redirect control.
                  npc_d        = npc_plus4;
                  annul_slot_d = 1'b0;
               end else if (taken) begin
                  npc_d        = {target[31:2], 2'b00};
                  // Only BA,a annuls the slot of a taken transfer.
                  annul_slot_d = annul_bit & uncond;
                  if (target[1:0] != 2'b00) begin
                     align_err_d = 1'b1;
                  end
               end else begin
                  npc_d        = npc_plus4;
                  annul_slot_d = annul_bit;
               end
            end
         end
         ST_TRAP_ENTRY: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         npc_q        <= RESET_PC + 32'd4;
         annul_slot_q <= 1'b0;
         saved_pc_q   <= 32'h0000_0000;
         saved_npc_q  <= 32'h0000_0000;
         trap_ack_q   <= 1'b0;
         align_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         npc_q        <= npc_d;
         annul_slot_q <= annul_slot_d;
         saved_pc_q   <= saved_pc_d;
         saved_npc_q  <= saved_npc_d;
         trap_ack_q   <= trap_ack_d;
         align_err_q  <= align_err_d;
      end
   end

   assign pc         = pc_q;
   assign npc        = npc_q;
   assign annul_slot = annul_slot_q;
   assign saved_pc   = saved_pc_q;
   assign saved_npc  = saved_npc_q;
   assign trap_ack   = trap_ack_q;
   assign align_err  = align_err_q;

endmodule

// File: tb/tb_pc_npc_unit.sv
// tb/tb_pc_npc_unit.sv - scoreboard bench for pc_npc_unit
module tb_pc_npc_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        advance = 1'b0;
   logic        ctrl_xfer = 1'b0;
   logic        taken = 1'b0;
   logic        uncond = 1'b0;
   logic        annul_bit = 1'b0;
   logic [31:0] target = 32'h0;
   logic        trap = 1'b0;
   logic [31:0] trap_vec = 32'h0;
   logic [31:0] pc, npc, saved_pc, saved_npc;
   logic        annul_slot, trap_ack, align_err;

   pc_npc_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .advance(advance), .ctrl_xfer(ctrl_xfer),
      .taken(taken), .uncond(uncond), .annul_bit(annul_bit), .target(target),
      .trap(trap), .trap_vec(trap_vec), .pc(pc), .npc(npc),
      .annul_slot(annul_slot), .saved_pc(saved_pc), .saved_npc(saved_npc),
      .trap_ack(trap_ack), .align_err(align_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] npc;
      logic        annul;
      logic [31:0] spc;
      logic [31:0] snpc;
      logic        ack;
      logic        aerr;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Architectural model of the instruction stream.
   logic [31:0] m_pc, m_npc, m_spc, m_snpc;
   logic        m_annul, m_ack, m_aerr;
   int          m_frozen;   // cycles remaining in which pc/npc are frozen after a trap

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.pc = m_pc; e.npc = m_npc; e.annul = m_annul;
      e.spc = m_spc; e.snpc = m_snpc; e.ack = m_ack; e.aerr = m_aerr;
      exp_q.push_back(e);
   endtask

   // Monitor: every clock edge and every reset assertion presents a new output set.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge reset);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("npc", npc, e.npc);
            chk("annul_slot", {31'b0, annul_slot}, {31'b0, e.annul});
            chk("saved_pc", saved_pc, e.spc);
            chk("saved_npc", saved_npc, e.snpc);
            chk("trap_ack", {31'b0, trap_ack}, {31'b0, e.ack});
            chk("align_err", {31'b0, align_err}, {31'b0, e.aerr});
         end
      end
   end

   // Called at a falling edge: asserts async reset, expects reset state at once and
   // again after the next rising edge while reset is still held.
   task automatic do_reset();
      reset = 1'b1;
      m_pc = 32'h0; m_npc = 32'h4; m_annul = 1'b0; m_spc = 32'h0; m_snpc = 32'h0;
      m_ack = 1'b0; m_aerr = 1'b0; m_frozen = 0;
      push_exp();
      push_exp();
      @(negedge clk);
   endtask

   // Drive one cycle of inputs at a falling edge and push what the next rising edge yields.
   task automatic cyc(input logic adv, input logic cx, input logic tk, input logic un,
                      input logic ab, input logic [31:0] tgt, input logic tr,
                      input logic [31:0] tv);
      reset = 1'b0;
      advance = adv; ctrl_xfer = cx; taken = tk; uncond = un; annul_bit = ab;
      target = tgt; trap = tr; trap_vec = tv;
      m_ack = 1'b0;
      if (m_frozen > 0) begin
         m_frozen--;
      end else if (tr) begin
         m_spc = m_pc; m_snpc = m_npc;
         m_pc = tv; m_npc = tv + 32'd4;
         m_annul = 1'b0; m_ack = 1'b1; m_frozen = 1;
      end else if (adv) begin
         logic redirect;
         redirect = !m_annul && cx && tk;
         m_pc = m_npc;
         if (redirect) begin
            m_npc = tgt & 32'hFFFF_FFFC;
            if (tgt % 4 != 0) m_aerr = 1'b1;
            m_annul = ab && un;
         end else begin
            m_annul = !m_annul && cx && ab;
            m_npc = m_pc + 32'd4;
         end
      end
      push_exp();
      @(negedge clk);
   endtask

   task automatic step(int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
   endtask

   initial begin
      @(negedge clk);
      // 1: straight-line fetch
      do_reset();
      step(3);
      // 2: taken Bicc at pc=8, a=0
      do_reset();
      step(2);
      cyc(1, 1, 1, 0, 0, 32'h100, 0, 32'h0);
      step(2);
      // 3: untaken Bicc,a at pc=8; the transfer in the annulled slot is ignored
      do_reset();
      step(2);
      cyc(1, 1, 0, 0, 1, 32'h300, 0, 32'h0);
      cyc(1, 1, 1, 1, 0, 32'h200, 0, 32'h0);
      step(1);
      // 4: BA,a to 0x40, then a misaligned 0x42 target; also a DCTI couple
      do_reset();
      cyc(1, 1, 1, 1, 1, 32'h40, 0, 32'h0);
      step(1);
      cyc(1, 1, 1, 0, 0, 32'h42, 0, 32'h0);
      cyc(1, 1, 1, 0, 0, 32'h80, 0, 32'h0);
      step(2);
      // 5: trap at pc=0x20 together with advance and a taken branch
      do_reset();
      step(8);
      cyc(1, 1, 1, 0, 0, 32'h500, 1, 32'h800);
      cyc(1, 0, 0, 0, 0, 32'h0, 1, 32'h900);
      step(2);
      // 6: npc wrap, then reset in the middle of a branch
      cyc(0, 0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFF8);
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      step(2);
      cyc(0, 0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
      step(1);
      cyc(1, 1, 1, 0, 0, 32'h700, 0, 32'h0);
      do_reset();
      step(2);
      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] tgt, tv;
         logic        cx;
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end else begin
            tgt = $urandom();
            if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
            tv = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + {28'h0, 2'b00, 2'($urandom_range(0, 3))} * 32'd4
                                            : ($urandom() & 32'hFFFF_FFF0);
            cx = ($urandom_range(0, 2) == 0);
            cyc($urandom_range(0, 3) != 0, cx, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), tgt, $urandom_range(0, 15) == 0, tv);
         end
      end
      @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
